// File: rtl/fwrisc_dbus_sram_responder.sv
// ----------------------------------------------------------------------------
// fwrisc_dbus_sram_responder
//
// Responder side of the fwrisc data bus. Accepts one load/store at a time,
// inserts WAIT_STATES stall cycles, drives a synchronous byte-enable SRAM
// with 1-cycle read latency, and returns a 1-cycle dready pulse. Accesses
// outside the SRAM window never touch the SRAM and complete with derr=1.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   dvalid/dwrite/daddr/  request from the initiator (held until dready)
//   dwdata/dstrb
//   dready/drdata/derr    completion pulse, load data, out-of-window flag
//   mem_en/mem_we/        SRAM strobe, write enable, word address,
//   mem_addr/mem_be/      byte enables and write data
//   mem_wdata
//   mem_rdata             SRAM read data, valid the cycle after a read strobe
// ----------------------------------------------------------------------------
module fwrisc_dbus_sram_responder #(
   parameter int unsigned ADDR_WIDTH  = 14,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ERR_DATA    = 32'h0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  dvalid,
   input  logic                  dwrite,
   input  logic [31:0]           daddr,
   input  logic [31:0]           dwdata,
   input  logic [3:0]            dstrb,
   output logic                  dready,
   output logic [31:0]           drdata,
   output logic                  derr,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DATA  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   localparam logic [3:0] WAIT_INIT = WAIT_STATES[3:0];

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            wait_cnt;
   logic [3:0]            wait_cnt_nxt;
   logic                  latch_req;
   logic                  req_oor;

   logic                  write_q;
   logic                  oor_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            strb_q;
   logic [31:0]           rdata_q;

   // Byte-offset bits carry no meaning on a word-wide bus.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^daddr[1:0];

   // Any address bit above the window makes the request out of range.
   assign req_oor = ((daddr >> (ADDR_WIDTH + 2)) != 32'd0);

   // State and wait-counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state logic; the counter saturates at zero instead of wrapping.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      latch_req    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dvalid) begin
               latch_req    = 1'b1;
               wait_cnt_nxt = WAIT_INIT;
               if (WAIT_INIT != 4'd0) begin
                  state_nxt = ST_WAIT;
               end else begin
                  state_nxt = ST_ISSUE;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt != 4'd0) begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end else begin
               wait_cnt_nxt = 4'd0;
            end
            if (wait_cnt <= 4'd1) begin
               state_nxt = ST_ISSUE;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_ISSUE: state_nxt = ST_DATA;
         ST_DATA:  state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Request capture: fields are frozen for the whole access, so a protocol
   // violation (dvalid dropping early) cannot corrupt an access in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_q <= 1'b0;
         oor_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         strb_q  <= 4'h0;
      end else if (latch_req) begin
         write_q <= dwrite;
         oor_q   <= req_oor;
         addr_q  <= daddr[ADDR_WIDTH+1:2];
         wdata_q <= dwdata;
         strb_q  <= dstrb;
      end
   end

   // Response data: stores report zero ahead of the out-of-window error value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata_q <= 32'h0;
      end else if (state == ST_DATA) begin
         if (write_q) begin
            rdata_q <= 32'h0;
         end else if (oor_q) begin
            rdata_q <= ERR_DATA;
         end else begin
            rdata_q <= mem_rdata;
         end
      end
   end

   assign dready    = (state == ST_RESP);
   assign derr      = (state == ST_RESP) & oor_q;
   assign drdata    = rdata_q;
   assign mem_en    = (state == ST_ISSUE) & ~oor_q;
   // An all-zero strobe store is a no-op on the SRAM, so it is issued as a read.
   assign mem_we    = (state == ST_ISSUE) & ~oor_q & write_q & (strb_q != 4'h0);
   assign mem_addr  = addr_q;
   assign mem_be    = strb_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_fwrisc_dbus_sram_responder.sv
module tb_fwrisc_dbus_sram_responder;

   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   typedef struct {
      int          lat;
      int          en_cnt;
      int          en_cyc;
      bit          we;
      logic [13:0] ma;
      logic [3:0]  mb;
      logic [31:0] mw;
      logic [31:0] rd;
      bit          er;
      bit          to;
      bit          after;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dvalid    [3];
   logic        dwrite    [3];
   logic [31:0] daddr     [3];
   logic [31:0] dwdata    [3];
   logic [3:0]  dstrb     [3];
   logic        dready    [3];
   logic [31:0] drdata    [3];
   logic        derr      [3];
   logic        mem_en    [3];
   logic        mem_we    [3];
   logic [13:0] mem_addr  [3];
   logic [3:0]  mem_be    [3];
   logic [31:0] mem_wdata [3];

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] model_mem [int];

   always #5 clk = ~clk;

   // Instance 0: no wait states, instance 1: 5, instance 2: 3.
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int WS = (g == 0) ? 0 : ((g == 1) ? 5 : 3);
      logic [31:0] rdata_s;
      logic [31:0] sram [0:16383];

      fwrisc_dbus_sram_responder #(
         .ADDR_WIDTH (14),
         .WAIT_STATES(WS),
         .ERR_DATA   (ERR)
      ) u_dut (
         .clock    (clk),
         .reset    (rst),
         .dvalid   (dvalid[g]),
         .dwrite   (dwrite[g]),
         .daddr    (daddr[g]),
         .dwdata   (dwdata[g]),
         .dstrb    (dstrb[g]),
         .dready   (dready[g]),
         .drdata   (drdata[g]),
         .derr     (derr[g]),
         .mem_en   (mem_en[g]),
         .mem_we   (mem_we[g]),
         .mem_addr (mem_addr[g]),
         .mem_be   (mem_be[g]),
         .mem_wdata(mem_wdata[g]),
         .mem_rdata(rdata_s)
      );

      initial begin
         for (int i = 0; i < 16384; i++) sram[i] <= 32'h0;
      end

      always @(posedge clk) begin
         if (mem_en[g]) begin
            if (mem_we[g]) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be[g][b]) sram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end else begin
               rdata_s <= sram[mem_addr[g]];
            end
         end
      end
   end

   function automatic int ws_of(input int g);
      return (g == 0) ? 0 : ((g == 1) ? 5 : 3);
   endfunction

   // Reference model: expected observation of one access, updates model memory.
   function automatic obs_t predict(input int g, input bit wr, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] st, input bit chained);
      obs_t        e;
      bit          oor;
      int          key;
      logic [31:0] w;
      oor      = (a >= 32'h0001_0000);
      key      = g * 65536 + int'(a[15:2]);
      w        = model_mem.exists(key) ? model_mem[key] : 32'h0;
      e.lat    = ws_of(g) + (chained ? 4 : 3);
      e.en_cnt = oor ? 0 : 1;
      e.en_cyc = e.lat - 2;
      e.we     = !oor && wr && (st != 4'h0);
      e.ma     = a[15:2];
      e.mb     = st;
      e.mw     = wd;
      e.er     = oor;
      e.to     = 1'b0;
      e.after  = 1'b0;
      if (oor) begin
         e.rd = wr ? 32'h0 : ERR;
      end else if (wr) begin
         e.rd = 32'h0;
         for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
         model_mem[key] = w;
      end else begin
         e.rd = w;
      end
      return e;
   endfunction

   // Drives one request from a negedge and observes it until dready (bounded).
   task automatic do_access(input int g, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input bit keep, output obs_t o);
      o.lat = 0; o.en_cnt = 0; o.en_cyc = -1; o.we = 1'b0; o.ma = 14'h0; o.mb = 4'h0;
      o.mw = 32'h0; o.rd = 32'h0; o.er = 1'b0; o.to = 1'b1; o.after = 1'b0;
      dvalid[g] = 1'b1; dwrite[g] = wr; daddr[g] = a; dwdata[g] = wd; dstrb[g] = st;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); @(negedge clk);
         if (mem_en[g] === 1'b1) begin
            o.en_cnt++; o.en_cyc = n; o.we = mem_we[g];
            o.ma = mem_addr[g]; o.mb = mem_be[g]; o.mw = mem_wdata[g];
         end
         if (dready[g] === 1'b1) begin
            o.lat = n; o.rd = drdata[g]; o.er = derr[g]; o.to = 1'b0;
            break;
         end
      end
      if (!keep) begin
         dvalid[g] = 1'b0;
         @(posedge clk); @(negedge clk);
         o.after = (dready[g] !== 1'b0) || (mem_en[g] !== 1'b0);
      end
   endtask

   task automatic test_reset();
      for (int g = 0; g < 3; g++) begin
         vectors++;
         if ({dready[g], derr[g], drdata[g], mem_en[g], mem_we[g], mem_addr[g], mem_be[g], mem_wdata[g]} !== 86'h0) begin
            miscompares++;
            $display("FAIL reset_outputs[%0d]: got dready=%b derr=%b drdata=%h mem_en=%b mem_we=%b addr=%h be=%h wdata=%h, want all 0",
                     g, dready[g], derr[g], drdata[g], mem_en[g], mem_we[g], mem_addr[g], mem_be[g], mem_wdata[g]);
         end
      end
   endtask

   task automatic test_store_load();
      obs_t o, e;
      e = predict(0, 1'b1, 32'h100, 32'hA5A5_1234, 4'hF, 1'b0);
      do_access(0, 1'b1, 32'h100, 32'hA5A5_1234, 4'hF, 1'b0, o);
      vectors++; if (o.lat != 3) begin miscompares++; $display("FAIL st_latency: got %0d want 3", o.lat); end
      vectors++; if (o.en_cnt != 1 || o.en_cyc != 1 || !o.we) begin miscompares++;
         $display("FAIL st_issue: got en_cnt=%0d en_cyc=%0d we=%b want 1 1 1", o.en_cnt, o.en_cyc, o.we); end
      vectors++; if (o.ma !== 14'h040 || o.mw !== 32'hA5A5_1234 || o.mb !== 4'hF) begin miscompares++;
         $display("FAIL st_mem_fields: got addr=%h wdata=%h be=%h want 040 a5a51234 f", o.ma, o.mw, o.mb); end
      vectors++; if (o.er || o.after) begin miscompares++; $display("FAIL st_derr_pulse: got derr=%b after=%b want 0 0", o.er, o.after); end

      e = predict(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
      do_access(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.lat != 3 || o.rd !== 32'hA5A5_1234) begin miscompares++;
         $display("FAIL ld_after_st: got lat=%0d rd=%h want 3 a5a51234", o.lat, o.rd); end
      vectors++; if (o.we || o.en_cnt != 1) begin miscompares++;
         $display("FAIL ld_issue: got we=%b en_cnt=%0d want 0 1", o.we, o.en_cnt); end

      e = predict(0, 1'b1, 32'h100, 32'h0000_BB00, 4'b0010, 1'b0);
      do_access(0, 1'b1, 32'h100, 32'h0000_BB00, 4'b0010, 1'b0, o);
      vectors++; if (o.mb !== 4'b0010 || !o.we) begin miscompares++;
         $display("FAIL partial_st: got be=%h we=%b want 2 1", o.mb, o.we); end
      e = predict(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
      do_access(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.rd !== 32'hA5A5_BB34 || o.rd !== e.rd) begin miscompares++;
         $display("FAIL partial_ld: got %h want a5a5bb34", o.rd); end
   endtask

   task automatic test_wait();
      obs_t o, e;
      e = predict(1, 1'b1, 32'h108, 32'hCAFE_F00D, 4'hF, 1'b0);
      do_access(1, 1'b1, 32'h108, 32'hCAFE_F00D, 4'hF, 1'b0, o);
      vectors++; if (o.lat != e.lat) begin miscompares++; $display("FAIL ws5_st_latency: got %0d want %0d", o.lat, e.lat); end
      e = predict(1, 1'b0, 32'h108, 32'h0, 4'h0, 1'b0);
      do_access(1, 1'b0, 32'h108, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.lat != 8 || o.en_cyc != 6) begin miscompares++;
         $display("FAIL ws5_ld_timing: got lat=%0d en_cyc=%0d want 8 6", o.lat, o.en_cyc); end
      vectors++; if (o.rd !== 32'hCAFE_F00D || o.after) begin miscompares++;
         $display("FAIL ws5_ld_data: got rd=%h after=%b want cafef00d 0", o.rd, o.after); end
   endtask

   task automatic test_oor();
      obs_t o, e;
      e = predict(0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 1'b0);
      do_access(0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 1'b0, o);
      e = predict(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0);
      do_access(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.en_cnt != 0 || o.rd !== ERR || !o.er || o.lat != 3) begin miscompares++;
         $display("FAIL oor_ld: got en_cnt=%0d rd=%h derr=%b lat=%0d want 0 %h 1 3", o.en_cnt, o.rd, o.er, o.lat, ERR); end
      e = predict(0, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 1'b0);
      do_access(0, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, o);
      vectors++; if (o.en_cnt != 0 || !o.er) begin miscompares++;
         $display("FAIL oor_st: got en_cnt=%0d derr=%b want 0 1", o.en_cnt, o.er); end
      e = predict(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      do_access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.rd !== 32'h1122_3344 || o.er) begin miscompares++;
         $display("FAIL oor_st_no_alias: got rd=%h derr=%b want 11223344 0", o.rd, o.er); end
      e = predict(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0);
      do_access(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.lat != 8 || o.rd !== ERR || !o.er || o.en_cnt != 0) begin miscompares++;
         $display("FAIL oor_ld_ws5: got lat=%0d rd=%h derr=%b en_cnt=%0d", o.lat, o.rd, o.er, o.en_cnt); end
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      e = predict(0, 1'b1, 32'h104, 32'h5566_7788, 4'hF, 1'b0);
      do_access(0, 1'b1, 32'h104, 32'h5566_7788, 4'hF, 1'b1, o);
      vectors++; if (o.lat != 3) begin miscompares++; $display("FAIL b2b_first: got %0d want 3", o.lat); end
      e = predict(0, 1'b0, 32'h104, 32'h0, 4'h0, 1'b1);
      do_access(0, 1'b0, 32'h104, 32'h0, 4'h0, 1'b1, o);
      vectors++; if (o.lat != 4 || o.rd !== 32'h5566_7788) begin miscompares++;
         $display("FAIL b2b_second: got lat=%0d rd=%h want 4 55667788", o.lat, o.rd); end
      e = predict(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
      do_access(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.lat != 4 || o.rd !== e.rd) begin miscompares++;
         $display("FAIL b2b_third: got lat=%0d rd=%h want 4 %h", o.lat, o.rd, e.rd); end
      e = predict(2, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0);
      do_access(2, 1'b0, 32'h104, 32'h0, 4'h0, 1'b1, o);
      e = predict(2, 1'b0, 32'h104, 32'h0, 4'h0, 1'b1);
      do_access(2, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.lat != 7) begin miscompares++; $display("FAIL b2b_ws3: got %0d want 7", o.lat); end
   endtask

   task automatic test_random();
      obs_t        o, e;
      int          g;
      bit          chained, keep, wr, oor;
      logic [31:0] a, wd;
      logic [3:0]  st;
      g = 0; chained = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (!chained) g = int'($urandom_range(0, 2));
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom;
            if (a < 32'h0001_0000) a = a | 32'h0001_0000;
         end else begin
            a = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
         end
         oor  = (a >= 32'h0001_0000);
         wd   = $urandom;
         st   = 4'($urandom_range(0, 15));
         keep = (i != 79) && ($urandom_range(0, 2) == 0);
         e = predict(g, wr, a, wd, st, chained);
         do_access(g, wr, a, wd, st, keep, o);
         vectors++;
         if (o.to || o.lat != e.lat || o.en_cnt != e.en_cnt || o.er != e.er || o.we != e.we) begin
            miscompares++;
            $display("FAIL rnd_ctrl[%0d]: g=%0d a=%h got lat=%0d en=%0d derr=%b we=%b want %0d %0d %b %b",
                     i, g, a, o.lat, o.en_cnt, o.er, o.we, e.lat, e.en_cnt, e.er, e.we);
         end
         if (!oor) begin
            vectors++;
            if (o.en_cyc != e.en_cyc || o.ma !== e.ma || o.mb !== e.mb || (e.we && o.mw !== e.mw)) begin
               miscompares++;
               $display("FAIL rnd_mem[%0d]: got cyc=%0d addr=%h be=%h wd=%h want %0d %h %h %h",
                        i, o.en_cyc, o.ma, o.mb, o.mw, e.en_cyc, e.ma, e.mb, e.mw);
            end
         end
         if (!(wr && oor)) begin
            vectors++;
            if (o.rd !== e.rd) begin
               miscompares++;
               $display("FAIL rnd_data[%0d]: g=%0d a=%h got %h want %h", i, g, a, o.rd, e.rd);
            end
         end
         if (!keep) begin
            vectors++;
            if (o.after) begin miscompares++; $display("FAIL rnd_pulse[%0d]: dready/mem_en high after response", i); end
         end
         chained = keep;
      end
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      int   bad;
      e = predict(2, 1'b1, 32'h200, 32'h0BAD_F00D, 4'hF, 1'b0);
      do_access(2, 1'b1, 32'h200, 32'h0BAD_F00D, 4'hF, 1'b0, o);
      dvalid[2] = 1'b1; dwrite[2] = 1'b0; daddr[2] = 32'h200; dstrb[2] = 4'h0;
      bad = 0;
      for (int n = 0; n < 2; n++) begin
         @(posedge clk); @(negedge clk);
         if (dready[2] !== 1'b0 || mem_en[2] !== 1'b0) bad++;
      end
      rst = 1'b1; dvalid[2] = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); @(negedge clk);
         if (n == 2) rst = 1'b0;
         if (dready[2] !== 1'b0 || mem_en[2] !== 1'b0) bad++;
      end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", bad); end
      e = predict(2, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
      do_access(2, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, o);
      vectors++; if (o.lat != 6 || o.rd !== 32'h0BAD_F00D) begin miscompares++;
         $display("FAIL rst_mid_reissue: got lat=%0d rd=%h want 6 0badf00d", o.lat, o.rd); end
   endtask

   initial begin
      rst = 1'b1;
      for (int g = 0; g < 3; g++) begin
         dvalid[g] = 1'b0; dwrite[g] = 1'b0; daddr[g] = 32'h0; dwdata[g] = 32'h0; dstrb[g] = 4'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      test_reset();
      test_store_load();
      test_wait();
      test_oor();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
